// File: rtl/filtdec_seq.sv
// rtl/filtdec_seq.sv - channel/decimation-phase sequencer for the shared filtdec datapath
//
// Tracks the channel index and the frame-within-decimation-period of an
// interleaved multi-channel sample stream. It drives the datapath enable and
// flags the last frame of each period. The dump flag and its channel tag are
// then delayed to line up with the arithmetic latency.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   cfg_decim      decimation factor N in frames (0 behaves as 1)
//   cfg_load       one-cycle pulse: latch cfg_decim, clear counters, go IDLE
//   in_valid       sample present this cycle
//   in_sof         start of frame (channel 0), qualified by in_valid
//   gate           datapath enable for this cycle's sample (combinational)
//   chan           channel index of this cycle's sample (combinational)
//   dump           this gated sample lies in the last frame of its period
//   out_valid      decimated result valid at datapath output
//   out_chan       channel tag of the out_valid result
//   running        sequencer locked to the stream
//   sync_err       sticky: in_sof arrived with the channel counter non-zero
module filtdec_seq #(
    parameter int nch = 4,
    parameter int cw  = 2,
    parameter int dw  = 8,
    parameter int lat = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [dw-1:0] cfg_decim,
    input  logic          cfg_load,
    input  logic          in_valid,
    input  logic          in_sof,
    output logic          gate,
    output logic [cw-1:0] chan,
    output logic          dump,
    output logic          out_valid,
    output logic [cw-1:0] out_chan,
    output logic          running,
    output logic          sync_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [cw-1:0] chan_last = cw'(nch - 1);

    state_t        state, state_nx;
    logic [cw-1:0] chan_cnt, chan_cnt_nx, chan_eff;
    logic [dw-1:0] frame_cnt, frame_cnt_nx, frame_eff;
    logic [dw-1:0] decim, last_frame;
    logic          sync_err_nx;
    logic          gate_int;

    function automatic logic [dw-1:0] decim_fix(input logic [dw-1:0] v);
        return (v == '0) ? dw'(1) : v;
    endfunction

    assign last_frame = decim - dw'(1);

    always_comb begin
        state_nx     = state;
        chan_cnt_nx  = chan_cnt;
        frame_cnt_nx = frame_cnt;
        sync_err_nx  = sync_err;
        gate_int     = 1'b0;
        chan_eff     = chan_cnt;
        frame_eff    = frame_cnt;

        if (cfg_load) begin
            // The sample arriving with a reconfiguration is dropped.
            state_nx     = IDLE;
            chan_cnt_nx  = '0;
            frame_cnt_nx = '0;
            sync_err_nx  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_sof) begin
                        gate_int  = 1'b1;
                        chan_eff  = '0;
                        frame_eff = '0;
                        state_nx  = RUN;
                    end
                end
                RUN: begin
                    gate_int = in_valid;
                    if (in_valid && in_sof) begin
                        // Resync: abandon any partial frame, restart the period.
                        if (chan_cnt != '0) begin
                            sync_err_nx = 1'b1;
                        end
                        chan_eff  = '0;
                        frame_eff = '0;
                    end
                end
                default: state_nx = IDLE;
            endcase

            if (gate_int) begin
                if (chan_eff == chan_last) begin
                    chan_cnt_nx  = '0;
                    frame_cnt_nx = (frame_eff == last_frame) ? '0 : frame_eff + dw'(1);
                end else begin
                    chan_cnt_nx  = chan_eff + cw'(1);
                    frame_cnt_nx = frame_eff;
                end
            end
        end
    end

    assign gate    = gate_int & ~rst;
    assign chan    = chan_eff;
    assign dump    = gate & (frame_eff == last_frame);
    assign running = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            chan_cnt  <= '0;
            frame_cnt <= '0;
            sync_err  <= 1'b0;
            decim     <= decim_fix(cfg_decim);
        end else begin
            state     <= state_nx;
            chan_cnt  <= chan_cnt_nx;
            frame_cnt <= frame_cnt_nx;
            sync_err  <= sync_err_nx;
            if (cfg_load) begin
                decim <= decim_fix(cfg_decim);
            end
        end
    end

    // Free-running alignment pipe: keeps shifting through input gaps and
    // reconfiguration so results already in flight still emerge.
    generate
        if (lat == 0) begin : g_nopipe
            assign out_valid = dump;
            assign out_chan  = chan;
        end else begin : g_pipe
            logic [lat-1:0] pv;
            logic [cw-1:0]  pc [lat];

            always_ff @(posedge clk) begin
                if (rst) begin
                    pv <= '0;
                    for (int i = 0; i < lat; i++) begin
                        pc[i] <= '0;
                    end
                end else begin
                    pv[0] <= dump;
                    pc[0] <= chan;
                    for (int i = 1; i < lat; i++) begin
                        pv[i] <= pv[i-1];
                        pc[i] <= pc[i-1];
                    end
                end
            end

            assign out_valid = pv[lat-1];
            assign out_chan  = pc[lat-1];
        end
    endgenerate

endmodule

// File: tb/tb_filtdec_seq.sv
// tb/tb_filtdec_seq.sv - randomized self-checking bench for filtdec_seq
module tb_filtdec_seq;

    localparam int NCH  = 4;
    localparam int CW   = 2;
    localparam int DW   = 8;
    localparam int LAT  = 4;
    localparam int MAXC = 6000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] cfg_decim = 8'd3;
    logic          cfg_load = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          gate;
    logic [CW-1:0] chan;
    logic          dump;
    logic          out_valid;
    logic [CW-1:0] out_chan;
    logic          running;
    logic          sync_err;

    filtdec_seq #(.nch(NCH), .cw(CW), .dw(DW), .lat(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_decim (cfg_decim),
        .cfg_load  (cfg_load),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .gate      (gate),
        .chan      (chan),
        .dump      (dump),
        .out_valid (out_valid),
        .out_chan  (out_chan),
        .running   (running),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: the stream is described by the sample index k since the
    // last sof; channel = k mod nch, frame = (k div nch) mod N.
    bit m_run = 0;
    bit m_err = 0;
    int m_k   = 0;
    int m_n   = 3;
    int cyc   = 0;
    int last_rst = -1;
    bit hist_v [MAXC];
    int hist_c [MAXC];
    int decim_tab [5] = '{0, 1, 2, 3, 5};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    endtask

    task automatic step(input bit r, input bit ld, input bit v, input bit s, input int d);
        bit e_gate, e_dump, e_ov;
        int kk, e_chan, e_oc, nn;
        @(negedge clk);
        rst = r; cfg_load = ld; in_valid = v; in_sof = s; cfg_decim = d[DW-1:0];
        #1;
        e_gate = 0;
        kk = m_k;
        if (!r && !ld) begin
            if (!m_run) begin
                if (v && s) begin e_gate = 1; kk = 0; end
            end else if (v) begin
                e_gate = 1;
                if (s) kk = 0;
            end
        end
        e_chan = kk % NCH;
        e_dump = e_gate && (((kk / NCH) % m_n) == m_n - 1);

        check_eq("gate", gate, e_gate);
        check_eq("dump", dump, e_dump);
        check_eq("running", running, m_run);
        check_eq("sync_err", sync_err, m_err);
        if (e_gate) check_eq("chan", chan, e_chan);

        hist_v[cyc] = e_dump;
        hist_c[cyc] = e_chan;
        e_ov = 0; e_oc = 0;
        if (cyc - LAT > last_rst) begin
            e_ov = hist_v[cyc-LAT];
            e_oc = hist_c[cyc-LAT];
        end
        check_eq("out_valid", out_valid, e_ov);
        if (e_ov) check_eq("out_chan", out_chan, e_oc);

        nn = (d == 0) ? 1 : d;
        if (r || ld) begin
            m_run = 0; m_k = 0; m_err = 0; m_n = nn;
            if (r) last_rst = cyc;
        end else if (e_gate) begin
            if (m_run && s && (m_k % NCH) != 0) m_err = 1;
            m_run = 1;
            m_k = kk + 1;
        end
        cyc++;
    endtask

    task automatic run_phase(input int ncyc, input int vprob, input bit gapped,
                             input int sofpm, input int loadpm, input int dd);
        bit v, s, ld;
        int d;
        for (int i = 0; i < ncyc; i++) begin
            v = gapped ? (i % 3 == 0) : ($urandom_range(0, 99) < vprob);
            if (!m_run)                s = ($urandom_range(0, 3) == 0);
            else if (m_k % NCH == 0)   s = $urandom_range(0, 1);
            else                       s = ($urandom_range(0, 999) < sofpm);
            ld = ($urandom_range(0, 999) < loadpm);
            d  = ld ? decim_tab[$urandom_range(0, 4)] : dd;
            step(1'b0, ld, v, s, d);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        step(1'b1, 0, 1, 1, 3);
        run_phase(400, 100, 0, 0, 0, 3);
        step(1'b1, 0, 0, 0, 1);
        run_phase(150, 100, 0, 0, 0, 1);
        step(1'b1, 0, 0, 0, 0);
        run_phase(150, 70, 0, 0, 0, 0);
        step(1'b0, 1, 1, 1, 2);
        run_phase(300, 0, 1, 0, 0, 2);
        step(1'b0, 1, 1, 0, 3);
        run_phase(400, 80, 0, 20, 0, 3);
        run_phase(1500, 75, 0, 5, 8, 3);
        step(1'b1, 0, 1, 0, 2);
        run_phase(300, 90, 0, 0, 0, 2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/filtdec_seq.md
Name: filtdec_seq

Overview:
- Sequencer for the time-multiplexed decimating filter datapath: tracks channel index and decimation phase of an interleaved multi-channel sample stream.
- Generates the `gate` enable for the shared delay-line / accumulator chain.
- Flags the dump cycle of each decimation period and produces output strobe and channel tag, aligned to the datapath latency.
- Sits between the ADC sample interleaver and the filtdec arithmetic.

Parameters:
- nch, 4, number of interleaved channels per frame (2..256)
- cw, 2, channel index width, ceil(log2(nch))
- dw, 8, width of decimation-factor register
- lat, 4, datapath latency in clocks from gate to result (0..32)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- cfg_decim  input  dw  decimation factor N in frames; 0 treated as 1
- cfg_load  input  1  one-cycle pulse: latch cfg_decim, return to IDLE
- in_valid  input  1  sample present this cycle
- in_sof  input  1  start of frame; qualified by in_valid; marks channel 0
- gate  output  1  datapath enable for this cycle's sample
- chan  output  cw  channel index of the current sample
- dump  output  1  current sample is the last frame of its decimation period
- out_valid  output  1  decimated result valid at datapath output
- out_chan  output  cw  channel tag of out_valid result
- running  output  1  sequencer in RUN state
- sync_err  output  1  sticky: in_sof seen out of place; cleared by rst or cfg_load

Behaviour:
- Reset (clk edge with rst=1): state IDLE; all outputs 0; chan counter 0; frame counter 0; delay pipeline cleared; decim register loaded with cfg_decim (0 -> 1).
- gate, chan and dump are combinational from in_valid/in_sof and registered counters; they are valid in the same cycle as the sample (zero latency).
- IDLE:
  - gate=0; samples are ignored.
  - in_valid & in_sof -> RUN. That sample is processed as ch0, frame 0: gate=1, chan=0, dump=(N==1).
- RUN:
  - gate=in_valid.
  - On each in_valid: chan counter increments. At nch-1 it wraps to 0 and the frame counter increments.
  - The frame counter wraps at N-1.
  - dump=1 for every sample whose frame counter equals N-1.
  - Gaps (in_valid=0) freeze all counters.
- Resync:
  - RUN & in_valid & in_sof with chan counter != 0: set sync_err.
  - The sample is treated as ch0, frame 0 (counters forced). Partial frame abandoned.
  - in_sof with counter already 0: no error.
- Missing sof: in_sof=0 when counter wraps to 0 is not an error (in_sof is optional after lock).
- cfg_load:
  - Highest priority after rst.
  - Latches cfg_decim and clears counters, sync_err and state (-> IDLE).
  - Sample in the same cycle is dropped: gate=0.
  - Pipeline contents keep draining.
- Output pipeline:
  - lat-stage free-running shift register of {dump&gate, chan}.
  - out_valid/out_chan are the stage-lat outputs.
  - lat=0: out_valid=dump&gate, combinational.
  - Not stalled by in_valid gaps; cleared only by rst.
- running=1 exactly when state==RUN.
- Width: frame counter dw bits; compare against N-1 computed in dw bits.

Test Plan:
- nch=4, lat=4, N=3, rst then continuous in_valid, sof on first sample:
  - chan cycles 0,1,2,3.
  - dump high on samples 8..11, 20..23, ...
  - out_valid high 4 cycles later with out_chan 0..3.
- N=1 (and cfg_decim=0):
  - dump=1 on every gated sample.
  - out_valid every sample after 4 clocks.
- Samples before first sof:
  - gate=0, running=0 until the sof sample.
  - First sof sample gives chan=0, running=1 from the following cycle.
- in_valid gapped 1-on/2-off, N=2:
  - counters advance only on valid.
  - dump pattern identical to the ungapped case per sample index.
- sof injected at chan=2 in RUN:
  - sync_err=1 and stays 1.
  - That sample gets chan=0 and frame counter restarts; cfg_load clears sync_err.
- cfg_load mid-frame with N 3->2:
  - gate=0 that cycle, running=0.
  - Pending out_valid still emerges lat cycles after its dump.
  - New period of 2 frames from next sof.
